// File: rtl/rf_read_port_sequencer.sv
// Steers one shared register-file read mux across both operands of a request,
// capturing each with same-cycle write bypass and returning them as a pair.
module rf_read_port_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic [ADDR_WIDTH-1:0] ADDR_A,
    input  logic [ADDR_WIDTH-1:0] ADDR_B,
    input  logic                  NEED_B,
    output logic [ADDR_WIDTH-1:0] SEL,
    input  logic [DATA_WIDTH-1:0] MUX_DATA,
    input  logic                  WR_EN,
    input  logic [ADDR_WIDTH-1:0] WR_ADDR,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [DATA_WIDTH-1:0] DATA_A,
    output logic [DATA_WIDTH-1:0] DATA_B
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD_A = 2'd1;
    localparam logic [1:0] RD_B = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic                  need_b;
    logic                  accept;
    logic [DATA_WIDTH-1:0] cap_data;

    assign REQ_READY = (state == IDLE) || ((state == RESP) && RSP_READY);
    assign accept    = REQ_VALID && REQ_READY;
    assign RSP_VALID = (state == RESP);

    always_comb begin
        SEL = '0;
        unique case (state)
            RD_A:    SEL = addr_a;
            RD_B:    SEL = addr_b;
            default: SEL = '0;
        endcase
    end

    // SEL is the address being read, so the bypass compares against it;
    // the register file commits WR_DATA on this same edge.
    always_comb begin
        cap_data = MUX_DATA;
        if ((ZERO_REG != 0) && (SEL == '0)) begin
            cap_data = '0;
        end else if (WR_EN && (WR_ADDR == SEL)) begin
            cap_data = WR_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            addr_a <= '0;
            addr_b <= '0;
            need_b <= 1'b0;
            DATA_A <= '0;
            DATA_B <= '0;
        end else begin
            if (accept) begin
                addr_a <= ADDR_A;
                addr_b <= ADDR_B;
                need_b <= NEED_B;
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state <= RD_A;
                    end
                end
                RD_A: begin
                    DATA_A <= cap_data;
                    if (need_b) begin
                        state <= RD_B;
                    end else begin
                        DATA_B <= '0;
                        state  <= RESP;
                    end
                end
                RD_B: begin
                    DATA_B <= cap_data;
                    state  <= RESP;
                end
                RESP: begin
                    if (RSP_READY) begin
                        state <= accept ? RD_A : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_read_port_sequencer.sv
// Bench for rf_read_port_sequencer: ROM-style mux model R[i]=i*0x1111,
// expected operand pairs queued at accept and checked at response.
module tb_rf_read_port_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [4:0]  ADDR_A;
    logic [4:0]  ADDR_B;
    logic        NEED_B;
    logic [4:0]  SEL;
    logic [31:0] MUX_DATA;
    logic        WR_EN;
    logic [4:0]  WR_ADDR;
    logic [31:0] WR_DATA;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [31:0] DATA_A;
    logic [31:0] DATA_B;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 CLK = ~CLK;

    assign MUX_DATA = 32'(SEL) * 32'h1111;

    rf_read_port_sequencer #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .ZERO_REG(1)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .REQ_VALID(REQ_VALID),
        .REQ_READY(REQ_READY),
        .ADDR_A(ADDR_A),
        .ADDR_B(ADDR_B),
        .NEED_B(NEED_B),
        .SEL(SEL),
        .MUX_DATA(MUX_DATA),
        .WR_EN(WR_EN),
        .WR_ADDR(WR_ADDR),
        .WR_DATA(WR_DATA),
        .RSP_VALID(RSP_VALID),
        .RSP_READY(RSP_READY),
        .DATA_A(DATA_A),
        .DATA_B(DATA_B)
    );

    function automatic logic [31:0] rv(input logic [4:0] x);
        return (x == 5'd0) ? 32'h0 : 32'(x) * 32'h1111;
    endfunction

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    // Issues one request from IDLE and returns observations up to RESP.
    // wph: 0 no write, 1 write during both reads, 2 write only in cycle 2.
    task automatic run_req(
        input  logic [4:0]  a,
        input  logic [4:0]  b,
        input  logic        nb,
        input  int          wph,
        input  logic [4:0]  wa,
        input  logic [31:0] wd,
        output logic        rdy,
        output logic [4:0]  s1,
        output logic [4:0]  s2,
        output logic        saw7,
        output int          lat
    );
        REQ_VALID = 1'b1;
        ADDR_A    = a;
        ADDR_B    = b;
        NEED_B    = nb;
        #1;
        rdy = REQ_READY;
        step;
        REQ_VALID = 1'b0;
        lat  = 1;
        s1   = SEL;
        s2   = 5'd0;
        saw7 = (SEL == 5'd7);
        WR_ADDR = wa;
        WR_DATA = wd;
        WR_EN   = (wph == 1);
        while (!RSP_VALID && lat < 10) begin
            step;
            lat++;
            if (lat == 2) s2 = SEL;
            if (!RSP_VALID && SEL == 5'd7) saw7 = 1'b1;
            WR_EN = (wph != 0) && (lat == 2) && !RSP_VALID;
        end
        WR_EN = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        step;
        step;
        RST = 1'b0;
        #1;
        n_cmp++;
        if (RSP_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rsp_valid: got %b want 0", RSP_VALID);
        end
        n_cmp++;
        if (DATA_A !== 32'h0 || DATA_B !== 32'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h/%h want 0/0", DATA_A, DATA_B);
        end
        n_cmp++;
        if (SEL !== 5'd0 || REQ_READY !== 1'b1) begin
            n_err++;
            $display("FAIL reset_sel_rdy: got %0d/%b want 0/1", SEL, REQ_READY);
        end
    endtask

    task automatic test_two_reads;
        logic rdy, saw7;
        logic [4:0] s1, s2;
        int lat;
        exp_t e;
        RSP_READY = 1'b1;
        sb.push_back('{rv(5'd3), rv(5'd7)});
        run_req(5'd3, 5'd7, 1'b1, 0, 5'd0, 32'h0, rdy, s1, s2, saw7, lat);
        n_cmp++;
        if (rdy !== 1'b1 || s1 !== 5'd3 || s2 !== 5'd7) begin
            n_err++;
            $display("FAIL two_sel: rdy=%b sel=%0d,%0d want 1 3,7", rdy, s1, s2);
        end
        n_cmp++;
        if (lat !== 3) begin
            n_err++;
            $display("FAIL two_latency: got %0d want 3", lat);
        end
        e = sb.pop_front();
        n_cmp++;
        if (DATA_A !== e.a || DATA_B !== e.b) begin
            n_err++;
            $display("FAIL two_data: got %h/%h want %h/%h", DATA_A, DATA_B, e.a, e.b);
        end
        n_cmp++;
        if (REQ_READY !== 1'b1) begin
            n_err++;
            $display("FAIL two_resp_ready: got %b want 1", REQ_READY);
        end
        step;
        n_cmp++;
        if (RSP_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL two_to_idle: rsp_valid %b want 0", RSP_VALID);
        end
    endtask

    task automatic test_single_read;
        logic rdy, saw7;
        logic [4:0] s1, s2;
        int lat;
        exp_t e;
        sb.push_back('{rv(5'd5), 32'h0});
        run_req(5'd5, 5'd7, 1'b0, 0, 5'd0, 32'h0, rdy, s1, s2, saw7, lat);
        n_cmp++;
        if (lat !== 2 || s1 !== 5'd5) begin
            n_err++;
            $display("FAIL single_lat_sel: got %0d/%0d want 2/5", lat, s1);
        end
        n_cmp++;
        if (saw7 !== 1'b0) begin
            n_err++;
            $display("FAIL single_no_b: saw sel 7 = %b want 0", saw7);
        end
        e = sb.pop_front();
        n_cmp++;
        if (DATA_A !== e.a || DATA_B !== e.b) begin
            n_err++;
            $display("FAIL single_data: got %h/%h want %h/%h", DATA_A, DATA_B, e.a, e.b);
        end
        step;
    endtask

    task automatic test_zero_reg;
        logic rdy, saw7;
        logic [4:0] s1, s2;
        int lat;
        exp_t e;
        sb.push_back('{32'h0, 32'h0});
        run_req(5'd0, 5'd0, 1'b1, 1, 5'd0, 32'hDEAD, rdy, s1, s2, saw7, lat);
        e = sb.pop_front();
        n_cmp++;
        if (lat !== 3 || DATA_A !== e.a || DATA_B !== e.b) begin
            n_err++;
            $display("FAIL zero_reg: lat %0d data %h/%h want 3 %h/%h",
                     lat, DATA_A, DATA_B, e.a, e.b);
        end
        step;
    endtask

    task automatic test_forward;
        logic rdy, saw7;
        logic [4:0] s1, s2;
        int lat;
        exp_t e;
        sb.push_back('{rv(5'd9), 32'hCAFE});
        run_req(5'd9, 5'd9, 1'b1, 2, 5'd9, 32'hCAFE, rdy, s1, s2, saw7, lat);
        e = sb.pop_front();
        n_cmp++;
        if (s1 !== 5'd9 || s2 !== 5'd9) begin
            n_err++;
            $display("FAIL fwd_sel: got %0d,%0d want 9,9", s1, s2);
        end
        n_cmp++;
        if (DATA_A !== e.a || DATA_B !== e.b) begin
            n_err++;
            $display("FAIL fwd_data: got %h/%h want %h/%h", DATA_A, DATA_B, e.a, e.b);
        end
        step;
        sb.push_back('{rv(5'd3), rv(5'd7)});
        run_req(5'd3, 5'd7, 1'b1, 2, 5'd3, 32'hBEEF, rdy, s1, s2, saw7, lat);
        e = sb.pop_front();
        n_cmp++;
        if (DATA_A !== e.a || DATA_B !== e.b) begin
            n_err++;
            $display("FAIL late_write: got %h/%h want %h/%h", DATA_A, DATA_B, e.a, e.b);
        end
        step;
    endtask

    task automatic test_backpressure;
        logic rdy, saw7;
        logic [4:0] s1, s2;
        int lat;
        int w;
        exp_t e;
        RSP_READY = 1'b0;
        sb.push_back('{rv(5'd10), rv(5'd11)});
        run_req(5'd10, 5'd11, 1'b1, 0, 5'd0, 32'h0, rdy, s1, s2, saw7, lat);
        e = sb.pop_front();
        n_cmp++;
        if (lat !== 3 || DATA_A !== e.a || DATA_B !== e.b) begin
            n_err++;
            $display("FAIL bp_first: lat %0d data %h/%h want 3 %h/%h",
                     lat, DATA_A, DATA_B, e.a, e.b);
        end
        for (int i = 0; i < 4; i++) begin
            REQ_VALID = 1'b1;
            ADDR_A    = 5'd1;
            ADDR_B    = 5'd2;
            NEED_B    = 1'b1;
            #1;
            n_cmp++;
            if (RSP_VALID !== 1'b1 || REQ_READY !== 1'b0 ||
                DATA_A !== e.a || DATA_B !== e.b) begin
                n_err++;
                $display("FAIL bp_hold%0d: v=%b rdy=%b data %h/%h want 1 0 %h/%h",
                         i, RSP_VALID, REQ_READY, DATA_A, DATA_B, e.a, e.b);
            end
            step;
        end
        RSP_READY = 1'b1;
        ADDR_A    = 5'd12;
        ADDR_B    = 5'd4;
        sb.push_back('{rv(5'd12), rv(5'd4)});
        #1;
        n_cmp++;
        if (REQ_READY !== 1'b1) begin
            n_err++;
            $display("FAIL bp_same_cycle_ready: got %b want 1", REQ_READY);
        end
        step;
        REQ_VALID = 1'b0;
        n_cmp++;
        if (SEL !== 5'd12 || RSP_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL bp_next_sel: sel %0d v %b want 12 0", SEL, RSP_VALID);
        end
        w = 0;
        while (!RSP_VALID && w < 6) begin
            step;
            w++;
        end
        e = sb.pop_front();
        n_cmp++;
        if (w !== 2 || DATA_A !== e.a || DATA_B !== e.b) begin
            n_err++;
            $display("FAIL bp_second: wait %0d data %h/%h want 2 %h/%h",
                     w, DATA_A, DATA_B, e.a, e.b);
        end
        step;
    endtask

    task automatic test_reset_mid;
        int seen;
        RSP_READY = 1'b1;
        REQ_VALID = 1'b1;
        ADDR_A    = 5'd2;
        ADDR_B    = 5'd6;
        NEED_B    = 1'b1;
        step;
        REQ_VALID = 1'b0;
        step;
        n_cmp++;
        if (SEL !== 5'd6) begin
            n_err++;
            $display("FAIL rst_in_rdb_sel: got %0d want 6", SEL);
        end
        RST = 1'b1;
        step;
        RST = 1'b0;
        n_cmp++;
        if (RSP_VALID !== 1'b0 || DATA_A !== 32'h0 || DATA_B !== 32'h0 ||
            REQ_READY !== 1'b1 || SEL !== 5'd0) begin
            n_err++;
            $display("FAIL rst_mid: v %b data %h/%h rdy %b sel %0d want 0 0/0 1 0",
                     RSP_VALID, DATA_A, DATA_B, REQ_READY, SEL);
        end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (RSP_VALID) seen++;
            step;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL rst_dropped: responses %0d want 0", seen);
        end
    endtask

    task automatic test_back_to_back;
        logic [4:0] ra[3] = '{5'd1, 5'd4, 5'd31};
        logic [4:0] rb[3] = '{5'd2, 5'd0, 5'd30};
        logic       rn[3] = '{1'b1, 1'b0, 1'b1};
        int   idx = 0;
        int   got = 0;
        int   last = -1;
        logic prev_nb = 1'b0;
        exp_t e;
        RSP_READY = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
            REQ_VALID = (idx < 3);
            if (idx < 3) begin
                ADDR_A = ra[idx];
                ADDR_B = rb[idx];
                NEED_B = rn[idx];
            end
            #1;
            if (RSP_VALID && RSP_READY && sb.size() > 0) begin
                e = sb.pop_front();
                got++;
                n_cmp++;
                if (DATA_A !== e.a || DATA_B !== e.b) begin
                    n_err++;
                    $display("FAIL b2b_data%0d: got %h/%h want %h/%h",
                             got, DATA_A, DATA_B, e.a, e.b);
                end
            end
            if (REQ_VALID && REQ_READY) begin
                sb.push_back('{rv(ra[idx]), rn[idx] ? rv(rb[idx]) : 32'h0});
                if (last >= 0) begin
                    n_cmp++;
                    if (cyc - last !== (prev_nb ? 3 : 2)) begin
                        n_err++;
                        $display("FAIL b2b_gap%0d: got %0d want %0d",
                                 idx, cyc - last, prev_nb ? 3 : 2);
                    end
                end
                last    = cyc;
                prev_nb = rn[idx];
                idx++;
            end
            step;
        end
        REQ_VALID = 1'b0;
        n_cmp++;
        if (got !== 3 || sb.size() !== 0) begin
            n_err++;
            $display("FAIL b2b_count: got %0d left %0d want 3 0", got, sb.size());
        end
        step;
    endtask

    initial begin
        RST       = 1'b1;
        REQ_VALID = 1'b0;
        ADDR_A    = 5'd0;
        ADDR_B    = 5'd0;
        NEED_B    = 1'b0;
        WR_EN     = 1'b0;
        WR_ADDR   = 5'd0;
        WR_DATA   = 32'h0;
        RSP_READY = 1'b1;
        test_reset;
        test_two_reads;
        test_single_read;
        test_zero_reg;
        test_forward;
        test_backpressure;
        test_reset_mid;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
